// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg: shared command layout and opcode legality check for the ALU command dispatcher
package alu_cmd_pkg;
  localparam int DATA_IN_WIDTH = 8;
  localparam int OPCODE_WIDTH = 2;
  localparam int CMD_WIDTH = OPCODE_WIDTH + 1 + 2 * DATA_IN_WIDTH;
  typedef struct packed {
    logic [OPCODE_WIDTH:0] op;
    logic [DATA_IN_WIDTH-1:0] a;
    logic [DATA_IN_WIDTH-1:0] b;
  } cmd_t;
  function automatic logic is_legal_op(input int unsigned op, input int unsigned num_ops);
    return op < num_ops;
  endfunction
endpackage

// File: rtl/alu_cmd_dispatch_fork_slot.sv
// fork_slot: one registered branch of the command fork; holds data until its consumer takes it
module fork_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             arst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             free_o
);
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    pend_d = load_i || (pend_q && !ready_i);
    data_d = load_i ? data_i : data_q;
  end
  always_ff @(posedge clk_i) begin
    if (!arst_n) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end
  assign data_o  = data_q;
  assign valid_o = pend_q;
  assign free_o  = !pend_q || ready_i;
endmodule

// File: rtl/alu_cmd_dispatch.sv
// alu_cmd_dispatch: forks legal commands into aligned A/B/opcode streams, drops illegal ones, counts both
module alu_cmd_dispatch #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int OPCODE_WIDTH = 2,
  parameter int NUM_OPS = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     arst_n,
  input  logic [DATA_IN_WIDTH-1:0] cmd_a,
  input  logic [DATA_IN_WIDTH-1:0] cmd_b,
  input  logic [OPCODE_WIDTH:0]    cmd_op,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [DATA_IN_WIDTH-1:0] a_data,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [DATA_IN_WIDTH-1:0] b_data,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [OPCODE_WIDTH:0]    op_data,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [CNT_WIDTH-1:0]     disp_count,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic                     err_sticky
);
  import alu_cmd_pkg::*;
  logic                 free_a, free_b, free_op, accept, load, drop;
  logic [CNT_WIDTH-1:0] disp_q, disp_d, drop_q, drop_d;
  logic                 err_q, err_d;
  assign cmd_ready = free_a && free_b && free_op;
  assign accept    = cmd_valid && cmd_ready;
  assign load      = accept && is_legal_op(32'(cmd_op), NUM_OPS);
  assign drop      = accept && !load;
  fork_slot #(.WIDTH(DATA_IN_WIDTH)) u_a (
    .clk_i(clk_i), .arst_n(arst_n), .load_i(load), .data_i(cmd_a), .ready_i(a_ready),
    .data_o(a_data), .valid_o(a_valid), .free_o(free_a)
  );
  fork_slot #(.WIDTH(DATA_IN_WIDTH)) u_b (
    .clk_i(clk_i), .arst_n(arst_n), .load_i(load), .data_i(cmd_b), .ready_i(b_ready),
    .data_o(b_data), .valid_o(b_valid), .free_o(free_b)
  );
  fork_slot #(.WIDTH(OPCODE_WIDTH + 1)) u_op (
    .clk_i(clk_i), .arst_n(arst_n), .load_i(load), .data_i(cmd_op), .ready_i(op_ready),
    .data_o(op_data), .valid_o(op_valid), .free_o(free_op)
  );
  // counters stick at all-ones rather than wrapping
  always_comb begin
    disp_d = (load && !(&disp_q)) ? disp_q + CNT_WIDTH'(1) : disp_q;
    drop_d = (drop && !(&drop_q)) ? drop_q + CNT_WIDTH'(1) : drop_q;
    err_d  = err_q || drop;
  end
  always_ff @(posedge clk_i) begin
    if (!arst_n) begin
      disp_q <= '0;
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      disp_q <= disp_d;
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end
  assign disp_count = disp_q;
  assign drop_count = drop_q;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_alu_cmd_dispatch.sv
// tb_alu_cmd_dispatch: random and directed stimulus checked against a queue-based model of the dispatcher
module tb_alu_cmd_dispatch;
  import alu_cmd_pkg::*;
  localparam int DW = 8, OW = 2, NOPS = 5, CW = 6;
  localparam int SAT = (1 << CW) - 1;
  logic clk_i = 1'b0, arst_n;
  logic [DW-1:0] cmd_a, cmd_b, a_data, b_data;
  logic [OW:0] cmd_op, op_data;
  logic cmd_valid, cmd_ready, a_valid, a_ready, b_valid, b_ready, op_valid, op_ready, err_sticky;
  logic [CW-1:0] disp_count, drop_count;
  int tests = 0, fails = 0;
  bit armed = 1'b0;
  logic [DW-1:0] qa[$], qb[$];
  logic [OW:0] qo[$];
  int m_disp = 0, m_drop = 0;
  bit m_err = 1'b0;
  cmd_t r;

  alu_cmd_dispatch #(.DATA_IN_WIDTH(DW), .OPCODE_WIDTH(OW), .NUM_OPS(NOPS), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .arst_n(arst_n), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .a_data(a_data), .a_valid(a_valid),
    .a_ready(a_ready), .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready), .disp_count(disp_count),
    .drop_count(drop_count), .err_sticky(err_sticky)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cmd(input logic v, input logic [OW:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    cmd_valid = v;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
  endtask

  task automatic readies(input logic ra, input logic rb, input logic ro);
    a_ready = ra;
    b_ready = rb;
    op_ready = ro;
  endtask

  // each branch is a queue of undelivered values; a branch can take a new command once empty or draining
  always @(negedge clk_i) begin
    bit rdy;
    rdy = (qa.size() == 0 || a_ready) && (qb.size() == 0 || b_ready) && (qo.size() == 0 || op_ready);
    if (armed) begin
      chk("cmd_ready", cmd_ready, rdy);
      chk("a_valid", a_valid, qa.size() != 0);
      chk("b_valid", b_valid, qb.size() != 0);
      chk("op_valid", op_valid, qo.size() != 0);
      if (qa.size() != 0) chk("a_data", a_data, qa[0]);
      if (qb.size() != 0) chk("b_data", b_data, qb[0]);
      if (qo.size() != 0) chk("op_data", op_data, qo[0]);
      chk("disp_count", disp_count, m_disp);
      chk("drop_count", drop_count, m_drop);
      chk("err_sticky", err_sticky, m_err);
    end
    if (!arst_n) begin
      qa.delete();
      qb.delete();
      qo.delete();
      m_disp = 0;
      m_drop = 0;
      m_err = 1'b0;
      armed = 1'b1;
    end else begin
      if (qa.size() != 0 && a_ready) void'(qa.pop_front());
      if (qb.size() != 0 && b_ready) void'(qb.pop_front());
      if (qo.size() != 0 && op_ready) void'(qo.pop_front());
      if (cmd_valid && rdy) begin
        if (cmd_op < NOPS) begin
          qa.push_back(cmd_a);
          qb.push_back(cmd_b);
          qo.push_back(cmd_op);
          if (m_disp < SAT) m_disp++;
        end else begin
          if (m_drop < SAT) m_drop++;
          m_err = 1'b1;
        end
      end
    end
  end

  initial begin
    arst_n = 1'b0;
    cmd(0, 0, 0, 0);
    readies(1, 1, 1);
    repeat (3) step();
    arst_n = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valids", {a_valid, b_valid, op_valid}, 0);
    chk("rst_data", {a_data, b_data, op_data}, 0);
    chk("rst_counts", {disp_count, drop_count, err_sticky}, 0);
    step();
    cmd(1, 2, 8'h5A, 8'h13);
    step();
    cmd(0, 0, 0, 0);
    @(negedge clk_i);
    chk("single_valid", {a_valid, b_valid, op_valid}, 3'b111);
    chk("single_a", a_data, 8'h5A);
    chk("single_b", b_data, 8'h13);
    chk("single_op", op_data, 2);
    chk("single_disp", disp_count, 1);
    step();
    @(negedge clk_i);
    chk("single_once", {a_valid, b_valid, op_valid}, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      cmd(1, 3'(i % 5), 8'(8'h10 + i), 8'(8'hF0 - i));
      @(negedge clk_i);
      chk("b2b_ready", cmd_ready, 1);
      step();
    end
    cmd(0, 0, 0, 0);
    @(negedge clk_i);
    chk("b2b_last_a", a_data, 8'h17);
    chk("b2b_disp", disp_count, 9);
    step();
    b_ready = 1'b0;
    cmd(1, 1, 8'h01, 8'hFF);
    step();
    cmd(1, 3, 8'h22, 8'h33);
    @(negedge clk_i);
    chk("stall_ready0", cmd_ready, 0);
    step();
    @(negedge clk_i);
    chk("stall_a_op_done", {a_valid, op_valid}, 0);
    chk("stall_b_hold", {b_valid, b_data}, 9'h1FF);
    chk("stall_ready1", cmd_ready, 0);
    step();
    @(negedge clk_i);
    chk("stall_b_hold2", {b_valid, b_data}, 9'h1FF);
    step();
    b_ready = 1'b1;
    @(negedge clk_i);
    chk("stall_release", cmd_ready, 1);
    step();
    cmd(0, 0, 0, 0);
    @(negedge clk_i);
    chk("stall_second", {a_data, b_data, op_data}, {8'h22, 8'h33, 3'd3});
    chk("stall_disp", disp_count, 11);
    step();
    cmd(1, 6, 8'hAA, 8'hBB);
    step();
    cmd(0, 0, 0, 0);
    @(negedge clk_i);
    chk("illegal_novalid", {a_valid, b_valid, op_valid}, 0);
    chk("illegal_drop", {drop_count, err_sticky}, {6'd1, 1'b1});
    step();
    cmd(1, 4, 8'h77, 8'h88);
    step();
    cmd(0, 0, 0, 0);
    @(negedge clk_i);
    chk("after_illegal", {a_valid, a_data, op_data}, {1'b1, 8'h77, 3'd4});
    chk("after_illegal_disp", disp_count, 12);
    repeat (3000) begin
      step();
      r.op = 3'($urandom_range(0, 7));
      r.a = 8'($urandom);
      r.b = 8'($urandom);
      cmd($urandom_range(0, 9) < 7, r.op, r.a, r.b);
      readies($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    step();
    cmd(0, 0, 0, 0);
    readies(1, 1, 1);
    repeat (2) step();
    @(negedge clk_i);
    chk("sat_disp", disp_count, SAT);
    chk("sat_drop", drop_count, SAT);
    chk("sat_err", err_sticky, 1);
    step();
    b_ready = 1'b0;
    cmd(1, 0, 8'h3C, 8'hC3);
    step();
    cmd(0, 0, 0, 0);
    step();
    @(negedge clk_i);
    chk("prerst_b", {a_valid, b_valid, b_data}, {2'b01, 8'hC3});
    step();
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
    @(negedge clk_i);
    chk("midrst_valids", {a_valid, b_valid, op_valid}, 0);
    chk("midrst_counts", {disp_count, drop_count, err_sticky}, 0);
    chk("midrst_ready", cmd_ready, 1);
    step();
    b_ready = 1'b1;
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_cmd_dispatch.md
Name: alu_cmd_dispatch

Overview:
- Upstream neighbour of the ALU/FIFO top.
- Accepts one combined command {opcode, operand A, operand B} on a single valid/ready stream.
- Forks each command into three independent registered streams that drive the A, B and opcode FIFO inputs, so the three FIFOs always stay aligned.
- Drops illegal opcodes before they reach the ALU.
- Keeps saturating counters of dispatched and dropped commands.

Parameters:
- DATA_IN_WIDTH, 8, operand width.
- OPCODE_WIDTH, 2, opcode port is OPCODE_WIDTH+1 bits wide (matches the opcode FIFO).
- NUM_OPS, 5, opcodes 0..NUM_OPS-1 are legal; opcodes >= NUM_OPS are illegal.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk_i  in  1  clock; rising edge.
- arst_n  in  1  reset; synchronous, active-low.
- cmd_a  in  DATA_IN_WIDTH  operand A.
- cmd_b  in  DATA_IN_WIDTH  operand B.
- cmd_op  in  OPCODE_WIDTH+1  opcode.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready.
- a_data  out  DATA_IN_WIDTH  to fifo_1_in.
- a_valid  out  1  to fifo_1_in_valid.
- a_ready  in  1  from fifo_1_in_ready.
- b_data  out  DATA_IN_WIDTH  to fifo_2_in.
- b_valid  out  1  to fifo_2_in_valid.
- b_ready  in  1  from fifo_2_in_ready.
- op_data  out  OPCODE_WIDTH+1  to fifo_4_in.
- op_valid  out  1  to fifo_4_in_valid.
- op_ready  in  1  from fifo_4_in_ready.
- disp_count  out  CNT_WIDTH  commands dispatched.
- drop_count  out  CNT_WIDTH  illegal commands dropped.
- err_sticky  out  1  set on the first drop.

Behaviour:
- Reset (arst_n=0 sampled at a clock edge):
  - All pending bits clear, so a_valid, b_valid, op_valid = 0.
  - a_data, b_data, op_data = 0.
  - disp_count, drop_count = 0; err_sticky = 0.
  - cmd_ready = 1 from the first cycle after reset.
  - Reset asserted mid-operation discards undelivered branch data; there is no partial delivery after reset.
- Each branch X in {a, b, op} has a data register and a pend_X bit. X_valid = pend_X.
- Branch X is free this cycle when !pend_X || X_ready.
- cmd_ready = free_a && free_b && free_op. It is combinational from the X_ready inputs and the registered pend bits only; it never depends on cmd_valid.
- Accept happens when cmd_valid && cmd_ready.
- Legal accept (cmd_op < NUM_OPS):
  - Load all three data registers and set all three pend bits next cycle.
  - disp_count increments.
  - Latency: 1 cycle from accept to X_valid.
- Illegal accept (cmd_op >= NUM_OPS):
  - Consume the command; do not load or set any pend bit.
  - drop_count increments; err_sticky goes to 1 and is cleared only by reset.
  - Branches whose handshake completes this cycle still clear normally.
- Branch handshake X_valid && X_ready with no legal accept in the same cycle: pend_X clears next cycle.
- Handshake and legal accept in the same cycle: pend_X stays 1 with the new data. This gives back-to-back throughput of 1 command per cycle when all readies are high.
- Branches complete independently (fork). One branch stalled holds cmd_ready low until that branch is freed. Already-delivered branches sit at valid=0 and are never re-sent.
- Valid/data stability: while X_valid=1 && !X_ready, X_data and X_valid hold.
- Counters saturate at all-ones; no wrap.

Decomposition:
- Package alu_cmd_pkg holds:
  - the legal-opcode check function, is_legal_op(op, NUM_OPS);
  - localparam CMD_WIDTH = OPCODE_WIDTH+1 + 2*DATA_IN_WIDTH;
  - a packed cmd_t struct {op, a, b} shared with the bench.
- One sub-module: fork_slot, parameter WIDTH. It holds the data register, the pend bit and the free output. It is instantiated three times.
- The counters stay in the top.

Test Plan:
- Reset, then idle:
  - cmd_ready = 1; all X_valid = 0; counters = 0.
- Single legal command, all readies high:
  - Stimulus: op=2, a=0x5A, b=0x13.
  - Next cycle: a_data=0x5A, b_data=0x13, op_data=2, all valid for exactly 1 cycle; disp_count=1.
- Back-to-back stream of 8 legal commands, readies high:
  - cmd_ready stays 1; one output per cycle, in order; disp_count=8.
- Stall on B:
  - Stimulus: b_ready=0 for 3 cycles after a command (op=1, a=0x01, b=0xFF).
  - a_valid and op_valid drop after 1 cycle; b_valid holds with 0xFF.
  - cmd_ready = 0 until b_ready=1; a second queued command is then accepted in the same cycle.
- Illegal opcode:
  - Stimulus: op=6 with NUM_OPS=5.
  - Command consumed; no X_valid; drop_count=1; err_sticky=1.
  - A following legal command dispatches normally.
- Reset mid-stall:
  - Stimulus: pend_b=1, then arst_n=0 for 1 cycle.
  - All valid = 0, counters = 0, err_sticky = 0; cmd_ready=1 next cycle.
